// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two memory requesters, the shared memory port and the arbiter.
// The arbiter takes the slave modport; the requesters/memory side takes master.
interface mem_port_arbiter_if;
    logic        core_req;
    logic [23:0] core_addr;
    logic [15:0] core_wdata;
    logic        core_we;
    logic        core_ack;
    logic [15:0] core_rdata;

    logic        disp_req;
    logic [23:0] disp_addr;
    logic [15:0] disp_wdata;
    logic        disp_we;
    logic        disp_ack;
    logic [15:0] disp_rdata;

    logic [23:0] address;
    logic [15:0] write_data;
    logic        write_enable;
    logic [15:0] read_data;
    logic        busy;
    logic        grant_id;

    modport slave (
        input  core_req, core_addr, core_wdata, core_we,
        input  disp_req, disp_addr, disp_wdata, disp_we,
        input  read_data,
        output core_ack, core_rdata, disp_ack, disp_rdata,
        output address, write_data, write_enable, busy, grant_id
    );

    modport master (
        output core_req, core_addr, core_wdata, core_we,
        output disp_req, disp_addr, disp_wdata, disp_we,
        output read_data,
        input  core_ack, core_rdata, disp_ack, disp_rdata,
        input  address, write_data, write_enable, busy, grant_id
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester (core / display fetch) arbiter for a single-ported memory,
// alternating on contention, with a configurable number of wait states per access.
module mem_port_arbiter #(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);

    //  state    | meaning
    //  S_IDLE   | no transaction; arbitrate on any request
    //  S_ACCESS | memory port driven from latched request, 1+WAIT_STATES cycles
    //  S_DONE   | owner's ack pulse, then back to idle
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [2:0] LP_LAST_CNT = 3'(WAIT_STATES);

    state_t      r_state;
    state_t      w_next_state;
    logic [2:0]  r_wait_cnt;
    logic        r_grant_id;
    logic        r_last_grant;
    logic [23:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_we;
    logic [15:0] r_core_rdata;
    logic [15:0] r_disp_rdata;

    logic        w_grant_valid;
    logic        w_winner;
    logic        w_access_last;

    // On contention the requester that did not win last time gets the port.
    assign w_grant_valid = bus.core_req | bus.disp_req;
    assign w_winner      = (bus.core_req & bus.disp_req) ? ~r_last_grant : bus.disp_req;
    assign w_access_last = (r_wait_cnt == LP_LAST_CNT);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_grant_valid) w_next_state = S_ACCESS;
            S_ACCESS: if (w_access_last) w_next_state = S_DONE;
            S_DONE:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wait_cnt   <= 3'd0;
            r_grant_id   <= 1'b0;
            r_last_grant <= 1'b1;
            r_addr       <= 24'd0;
            r_wdata      <= 16'd0;
            r_we         <= 1'b0;
            r_core_rdata <= 16'd0;
            r_disp_rdata <= 16'd0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_valid) begin
                        r_addr       <= w_winner ? bus.disp_addr  : bus.core_addr;
                        r_wdata      <= w_winner ? bus.disp_wdata : bus.core_wdata;
                        r_we         <= w_winner ? bus.disp_we    : bus.core_we;
                        r_grant_id   <= w_winner;
                        r_last_grant <= w_winner;
                        r_wait_cnt   <= 3'd0;
                    end
                end
                S_ACCESS: begin
                    r_wait_cnt <= r_wait_cnt + 3'd1;
                    if (w_access_last && !r_we) begin
                        if (r_grant_id) r_disp_rdata <= bus.read_data;
                        else            r_core_rdata <= bus.read_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // Port outputs decode from the state register, so reset clears the strobe asynchronously.
    assign bus.address      = (r_state == S_ACCESS) ? r_addr  : 24'd0;
    assign bus.write_data   = (r_state == S_ACCESS) ? r_wdata : 16'd0;
    assign bus.write_enable = (r_state == S_ACCESS) ? r_we    : 1'b0;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.grant_id     = r_grant_id;
    assign bus.core_ack     = (r_state == S_DONE) && !r_grant_id;
    assign bus.disp_ack     = (r_state == S_DONE) &&  r_grant_id;
    assign bus.core_rdata   = r_core_rdata;
    assign bus.disp_rdata   = r_disp_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with no wait states,
// one with three, sharing clock and reset.
module tb_mem_port_arbiter;

    logic clk;
    logic rst;
    int   vec;
    int   err;

    mem_port_arbiter_if b0 ();
    mem_port_arbiter_if b3 ();

    mem_port_arbiter #(.WAIT_STATES(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    mem_port_arbiter #(.WAIT_STATES(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        b0.core_req = 0; b0.core_addr = 0; b0.core_wdata = 0; b0.core_we = 0;
        b0.disp_req = 0; b0.disp_addr = 0; b0.disp_wdata = 0; b0.disp_we = 0;
        b0.read_data = 0;
        b3.core_req = 0; b3.core_addr = 0; b3.core_wdata = 0; b3.core_we = 0;
        b3.disp_req = 0; b3.disp_addr = 0; b3.disp_wdata = 0; b3.disp_we = 0;
        b3.read_data = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        tick(); tick();
        vec++; if (b0.busy !== 1'b0) begin err++; $display("FAIL reset_busy: got %b want 0", b0.busy); end
        vec++; if (b0.address !== 24'd0) begin err++; $display("FAIL reset_addr: got %h want 0", b0.address); end
        vec++; if (b0.write_enable !== 1'b0) begin err++; $display("FAIL reset_we: got %b want 0", b0.write_enable); end
        vec++; if ({b0.core_ack, b0.disp_ack} !== 2'b00) begin err++; $display("FAIL reset_acks: got %b want 00", {b0.core_ack, b0.disp_ack}); end
        vec++; if ({b0.core_rdata, b0.disp_rdata} !== 32'd0) begin err++; $display("FAIL reset_rdata: got %h want 0", {b0.core_rdata, b0.disp_rdata}); end
        vec++; if (b0.grant_id !== 1'b0) begin err++; $display("FAIL reset_grant: got %b want 0", b0.grant_id); end
        vec++; if (b3.busy !== 1'b0) begin err++; $display("FAIL reset_busy3: got %b want 0", b3.busy); end
        rst = 1'b0;
    endtask

    task automatic test_core_read();
        b0.core_req = 1; b0.core_addr = 24'h000010; b0.core_we = 0; b0.read_data = 16'hBEEF;
        tick();
        vec++; if (b0.address !== 24'h000010) begin err++; $display("FAIL rd_addr: got %h want 000010", b0.address); end
        vec++; if (b0.busy !== 1'b1) begin err++; $display("FAIL rd_busy: got %b want 1", b0.busy); end
        vec++; if (b0.core_ack !== 1'b0) begin err++; $display("FAIL rd_early_ack: got %b want 0", b0.core_ack); end
        tick();
        vec++; if (b0.core_ack !== 1'b1) begin err++; $display("FAIL rd_ack: got %b want 1", b0.core_ack); end
        vec++; if (b0.disp_ack !== 1'b0) begin err++; $display("FAIL rd_other_ack: got %b want 0", b0.disp_ack); end
        vec++; if (b0.core_rdata !== 16'hBEEF) begin err++; $display("FAIL rd_data: got %h want beef", b0.core_rdata); end
        vec++; if (b0.address !== 24'd0) begin err++; $display("FAIL rd_addr_done: got %h want 0", b0.address); end
        b0.core_req = 0;
        tick();
        vec++; if (b0.core_ack !== 1'b0 || b0.busy !== 1'b0) begin err++; $display("FAIL rd_end: ack %b busy %b want 0 0", b0.core_ack, b0.busy); end
    endtask

    task automatic test_disp_write();
        b0.disp_req = 1; b0.disp_addr = 24'h020100; b0.disp_wdata = 16'h1234; b0.disp_we = 1;
        b0.read_data = 16'h7777;
        tick();
        vec++; if (b0.write_enable !== 1'b1) begin err++; $display("FAIL wr_we: got %b want 1", b0.write_enable); end
        vec++; if (b0.address !== 24'h020100) begin err++; $display("FAIL wr_addr: got %h want 020100", b0.address); end
        vec++; if (b0.write_data !== 16'h1234) begin err++; $display("FAIL wr_data: got %h want 1234", b0.write_data); end
        vec++; if (b0.grant_id !== 1'b1) begin err++; $display("FAIL wr_grant: got %b want 1", b0.grant_id); end
        tick();
        vec++; if (b0.write_enable !== 1'b0) begin err++; $display("FAIL wr_we_off: got %b want 0", b0.write_enable); end
        vec++; if (b0.disp_ack !== 1'b1 || b0.core_ack !== 1'b0) begin err++; $display("FAIL wr_ack: disp %b core %b want 1 0", b0.disp_ack, b0.core_ack); end
        vec++; if (b0.disp_rdata !== 16'd0) begin err++; $display("FAIL wr_disp_rdata: got %h want 0", b0.disp_rdata); end
        vec++; if (b0.core_rdata !== 16'hBEEF) begin err++; $display("FAIL wr_core_rdata: got %h want beef", b0.core_rdata); end
        b0.disp_req = 0; b0.disp_we = 0;
        tick();
        vec++; if (b0.disp_ack !== 1'b0) begin err++; $display("FAIL wr_ack_once: got %b want 0", b0.disp_ack); end
    endtask

    task automatic test_alternate();
        logic [3:0] exp_gid;
        rst = 1'b1;
        tick();
        b0.core_req = 1; b0.core_addr = 24'h000040; b0.core_we = 0;
        b0.disp_req = 1; b0.disp_addr = 24'h010040; b0.disp_we = 0;
        b0.read_data = 16'hA5A5;
        rst = 1'b0;
        exp_gid = 4'b1010;
        for (int t = 0; t < 4; t++) begin
            tick();
            vec++; if (b0.grant_id !== exp_gid[t]) begin err++; $display("FAIL alt_grant%0d: got %b want %b", t, b0.grant_id, exp_gid[t]); end
            tick();
            vec++; if ({b0.core_ack, b0.disp_ack} !== (exp_gid[t] ? 2'b01 : 2'b10)) begin
                err++; $display("FAIL alt_ack%0d: got %b want %b", t, {b0.core_ack, b0.disp_ack}, (exp_gid[t] ? 2'b01 : 2'b10));
            end
            tick();
            vec++; if ({b0.core_ack, b0.disp_ack, b0.busy} !== 3'b000) begin err++; $display("FAIL alt_idle%0d: got %b want 000", t, {b0.core_ack, b0.disp_ack, b0.busy}); end
        end
        b0.core_req = 0; b0.disp_req = 0;
        vec++; if ({b0.core_rdata, b0.disp_rdata} !== {16'hA5A5, 16'hA5A5}) begin err++; $display("FAIL alt_rdata: got %h want a5a5a5a5", {b0.core_rdata, b0.disp_rdata}); end
        tick();
    endtask

    task automatic test_wait_states();
        logic [15:0] rd_vals [4];
        rd_vals[0] = 16'h1111; rd_vals[1] = 16'h2222; rd_vals[2] = 16'h3333; rd_vals[3] = 16'h4444;
        b3.core_req = 1; b3.core_addr = 24'h00ABCD; b3.core_we = 0;
        tick();
        for (int k = 0; k < 3; k++) begin
            b3.read_data = rd_vals[k];
            vec++; if (b3.address !== 24'h00ABCD || b3.busy !== 1'b1) begin err++; $display("FAIL ws_access%0d: addr %h busy %b want 00abcd 1", k, b3.address, b3.busy); end
            tick();
            vec++; if (b3.core_ack !== 1'b0 || b3.core_rdata !== 16'd0) begin err++; $display("FAIL ws_early%0d: ack %b rdata %h want 0 0000", k, b3.core_ack, b3.core_rdata); end
        end
        b3.read_data = rd_vals[3];
        vec++; if (b3.address !== 24'h00ABCD) begin err++; $display("FAIL ws_access3: got %h want 00abcd", b3.address); end
        tick();
        vec++; if (b3.core_ack !== 1'b1) begin err++; $display("FAIL ws_ack: got %b want 1", b3.core_ack); end
        vec++; if (b3.core_rdata !== 16'h4444) begin err++; $display("FAIL ws_rdata: got %h want 4444", b3.core_rdata); end
        vec++; if (b3.address !== 24'd0) begin err++; $display("FAIL ws_addr_done: got %h want 0", b3.address); end
        b3.core_req = 0;
        tick();
        vec++; if (b3.core_ack !== 1'b0 || b3.busy !== 1'b0) begin err++; $display("FAIL ws_end: ack %b busy %b want 0 0", b3.core_ack, b3.busy); end
    endtask

    task automatic test_addr_hold();
        b3.core_req = 1; b3.core_addr = 24'h000100; b3.core_we = 0; b3.read_data = 16'h0F0F;
        tick();
        b3.core_addr = 24'hFFFFFF; b3.core_req = 0; b3.disp_req = 1; b3.disp_addr = 24'h123456;
        for (int k = 0; k < 3; k++) begin
            tick();
            vec++; if (b3.address !== 24'h000100 || b3.grant_id !== 1'b0) begin
                err++; $display("FAIL hold%0d: addr %h gid %b want 000100 0", k, b3.address, b3.grant_id);
            end
        end
        b3.disp_req = 0;
        tick(); tick();
        vec++; if (b3.core_rdata !== 16'h0F0F) begin err++; $display("FAIL hold_rdata: got %h want 0f0f", b3.core_rdata); end
    endtask

    task automatic test_reset_mid_write();
        b0.core_req = 1; b0.core_addr = 24'h000222; b0.core_wdata = 16'h5555; b0.core_we = 1;
        tick();
        vec++; if (b0.write_enable !== 1'b1) begin err++; $display("FAIL rst_we_pre: got %b want 1", b0.write_enable); end
        #2;
        rst = 1'b1;
        b0.core_req = 0; b0.core_we = 0;
        #1;
        vec++; if (b0.write_enable !== 1'b0) begin err++; $display("FAIL rst_we_async: got %b want 0", b0.write_enable); end
        vec++; if (b0.busy !== 1'b0) begin err++; $display("FAIL rst_busy: got %b want 0", b0.busy); end
        #2;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            vec++; if (b0.core_ack !== 1'b0 || b0.busy !== 1'b0) begin err++; $display("FAIL rst_no_ack%0d: ack %b busy %b want 0 0", k, b0.core_ack, b0.busy); end
        end
        b0.core_req = 1; b0.core_addr = 24'h000333;
        b0.disp_req = 1; b0.disp_addr = 24'h040000;
        tick();
        vec++; if (b0.grant_id !== 1'b0 || b0.address !== 24'h000333) begin
            err++; $display("FAIL rst_contention: gid %b addr %h want 0 000333", b0.grant_id, b0.address);
        end
        b0.core_req = 0; b0.disp_req = 0;
        tick(); tick();
    endtask

    initial begin
        vec = 0;
        err = 0;
        test_reset();
        test_core_read();
        test_disp_write();
        test_alternate();
        test_wait_states();
        test_addr_hold();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter WAIT_STATES, default 0: extra memory cycles per access, range 0..7.
REQ-002 clk  in  1  sole clock; all state changes on the rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 CoreReq  in  1  core requests one memory access.
REQ-005 CoreAddr  in  24  core address: {bank[7:0], word[15:0]}.
REQ-006 CoreWData  in  16  core write data.
REQ-007 CoreWE  in  1  core access is a write (1) or a read (0).
REQ-008 CoreAck  out  1  one-cycle pulse: core access complete.
REQ-009 CoreRData  out  16  read data captured for the core.
REQ-010 DispReq, DispAddr, DispWData, DispWE  in  1/24/16/1  display-fetch requester; same meanings as the core ports.
REQ-011 DispAck, DispRData  out  1/16  display requester's ack pulse and read data.
REQ-012 Address  out  24  shared memory port address.
REQ-013 WriteData  out  16  shared memory port write data.
REQ-014 WriteEnable  out  1  shared memory port write strobe.
REQ-015 ReadData  in  16  memory read data; valid in the same cycle that Address is driven.
REQ-016 Busy  out  1  high in any state except IDLE.
REQ-017 GrantId  out  1  owner of the current transaction: 0 = core, 1 = display.

Function
REQ-018 The block SHALL implement a 3-state FSM:
- IDLE -> ACCESS when CoreReq or DispReq is high.
- ACCESS -> DONE when the wait counter reaches WAIT_STATES.
- DONE -> IDLE unconditionally.
REQ-019 Arbitration SHALL occur only in IDLE:
- Only one request high -> that requester wins.
- Both high -> the requester not equal to LastGrant wins.
REQ-020 On grant, the block SHALL register the winner's Addr, WData and WE, and load GrantId and LastGrant with the winner id.
REQ-021 Requester inputs SHALL be ignored from grant until return to IDLE; changes to address, data or request are not seen mid-transaction.
REQ-022 In ACCESS, Address, WriteData and WriteEnable SHALL be driven from the registered copies.
REQ-023 Outside ACCESS, Address = 0, WriteData = 0 and WriteEnable = 0.
REQ-024 ACCESS SHALL last exactly 1+WAIT_STATES cycles:
- 3-bit wait counter cleared on entry to ACCESS.
- Counter increments each ACCESS cycle.
REQ-025 On the final ACCESS edge of a read, ReadData SHALL be captured into the owner's RData register; the other RData register is unchanged.
REQ-026 On a write, neither RData register SHALL change.
REQ-027 In DONE, the owner's Ack SHALL be high for exactly one cycle; the other Ack stays low.
REQ-028 Requester protocol:
- Hold Req until Ack.
- A Req still high in the cycle after Ack is a new request.
- A Req dropped before Ack does not cancel the transaction.
REQ-029 Timing SHALL be: latency from Req high in IDLE to Ack = 2+WAIT_STATES cycles; minimum spacing between grants = 3+WAIT_STATES cycles.
REQ-030 With both requesters continuously requesting, grants SHALL strictly alternate; neither requester waits more than one transaction.

Reset
REQ-031 While reset is high, the block SHALL hold:
- FSM = IDLE.
- LastGrant = 1, so the core wins the first contention.
- Wait counter = 0; GrantId = 0.
- Both Acks = 0; both RData = 0.
- Address = 0, WriteData = 0, WriteEnable = 0; Busy = 0.
REQ-032 Reset asserted mid-ACCESS SHALL deassert WriteEnable immediately, without waiting for a clock edge, and no Ack is issued for the aborted transaction.
REQ-033 After reset deasserts, the first arbitration SHALL occur on the first rising edge that sees a Req high.

Verification
REQ-034 Core read, WAIT_STATES=0, CoreAddr=0x000010, memory returns 0xBEEF:
- Address = 0x000010 one cycle after Req.
- CoreAck pulses two cycles after Req.
- CoreRData = 0xBEEF.
REQ-035 Display write, DispAddr=0x020100, DispWData=0x1234:
- WriteEnable = 1 for exactly one cycle, with those Address/WriteData values.
- DispAck pulses once.
- DispRData unchanged.
REQ-036 Both Reqs held high from reset for four transactions:
- GrantId sequence 0,1,0,1.
- Ack pulses alternate, 3 cycles apart.
REQ-037 WAIT_STATES=3, core read:
- ACCESS lasts 4 cycles.
- ReadData sampled only on the 4th ACCESS edge.
- CoreAck 5 cycles after Req.
REQ-038 Reset pulsed during the ACCESS cycle of a core write:
- WriteEnable drops asynchronously.
- No CoreAck.
- Busy = 0.
- The next contention is won by the core.
REQ-039 CoreAddr changed during ACCESS: Address keeps the value latched at grant.
